// File: rtl/outbuf_drain_sched.sv
// Write/read scheduler for the per-channel output RAMs: pointer/flag tracking and round-robin drain.
// Optional build macro OUTBUF_BURST_DRAIN_EN keeps the grant on one channel until it empties or drain_en drops.
module outbuf_drain_sched #(
  parameter int NCH    = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          wr_req,
  output logic [NCH-1:0]          ram_wren,
  output logic [NCH*ADDR_W-1:0]   ram_wraddr,
  output logic [NCH-1:0]          ram_rden,
  output logic [NCH*ADDR_W-1:0]   ram_rdaddr,
  input  logic [NCH*DATA_W-1:0]   ram_q,
  input  logic                    drain_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [1:0]              out_chan,
  output logic [NCH-1:0]          full,
  output logic [NCH-1:0]          empty,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_wr_ptr [NCH];
  logic [ADDR_W:0]   r_rd_ptr [NCH];
  logic [1:0]        r_grant;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_chan;
  logic              r_overflow;
  logic [1:0]        w_pick;
  logic [1:0]        w_idx;
  logic              w_any;
  logic [DATA_W-1:0] w_q_sel;
`ifdef OUTBUF_BURST_DRAIN_EN
  logic              r_sticky;
`endif

  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign overflow  = r_overflow;

  always_comb begin
    empty      = '0;
    full       = '0;
    ram_wren   = '0;
    ram_rden   = '0;
    ram_wraddr = '0;
    ram_rdaddr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
      full[i]  = ((r_wr_ptr[i] - r_rd_ptr[i]) == FULL_DIFF);
      ram_wren[i] = wr_req[i] & ~full[i];
      ram_rden[i] = (r_state == S_ISSUE) && (r_grant == 2'(i));
      ram_wraddr[i*ADDR_W +: ADDR_W] = r_wr_ptr[i][ADDR_W-1:0];
      ram_rdaddr[i*ADDR_W +: ADDR_W] = r_rd_ptr[i][ADDR_W-1:0];
    end
  end

  // Search starts one past the previous grant, so channel 0 wins first after reset.
  always_comb begin
    w_pick = r_grant;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_idx = 2'((32'(r_grant) + k) % NCH);
      if (!w_any && !empty[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
`ifdef OUTBUF_BURST_DRAIN_EN
    if (r_sticky && !empty[r_grant]) begin
      w_any  = 1'b1;
      w_pick = r_grant;
    end
`endif
  end

  always_comb begin
    w_q_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_grant == 2'(i)) w_q_sel = ram_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (drain_en && w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_grant    <= 2'(NCH - 1);
      r_out_data <= '0;
      r_out_chan <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ram_wren[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_ONE;
        if (ram_rden[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PTR_ONE;
      end
      if (|(wr_req & full)) r_overflow <= 1'b1;
      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) r_grant <= w_pick;
      if (r_state == S_WAIT) begin
        r_out_data <= w_q_sel;
        r_out_chan <= r_grant;
      end
    end
  end

`ifdef OUTBUF_BURST_DRAIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (r_state == S_HOLD && out_ready) begin
      r_sticky <= drain_en;
    end else if (r_state == S_IDLE && !drain_en) begin
      r_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_outbuf_drain_sched.sv
// Bench for outbuf_drain_sched: RAM model, per-channel queue reference model, directed and random steps.
module tb_outbuf_drain_sched;
  localparam int NCH   = 3;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    wr_req = '0;
  logic [NCH-1:0]    ram_wren;
  logic [NCH*AW-1:0] ram_wraddr;
  logic [NCH-1:0]    ram_rden;
  logic [NCH*AW-1:0] ram_rdaddr;
  logic [NCH*DW-1:0] ram_q;
  logic              drain_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_chan;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic              overflow;

  outbuf_drain_sched #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .drain_en(drain_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] wdata [NCH];
  logic [DW-1:0] mem   [NCH][DEPTH];
  logic [DW-1:0] qreg  [NCH];

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ram_wren[i]) mem[i][ram_wraddr[i*AW +: AW]] <= wdata[i];
      if (ram_rden[i]) qreg[i] <= mem[i][ram_rdaddr[i*AW +: AW]];
    end
  end
  assign ram_q = {qreg[2], qreg[1], qreg[0]};

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mq [NCH][$];
  int  m_wcnt [NCH];
  int  m_last = NCH - 1;
  bit  m_ovf = 1'b0;
  bit  m_sticky = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick();
`ifdef OUTBUF_BURST_DRAIN_EN
    if (m_sticky && mq[m_last].size() > 0) return m_last;
`endif
    for (int k = 1; k <= NCH; k++) begin
      int c = (m_last + k) % NCH;
      if (mq[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    wr_req = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_wcnt[c] = 0;
    end
    m_last = NCH - 1;
    m_ovf = 1'b0;
    m_sticky = 1'b0;
  endtask

  task automatic set_drain(input logic v);
    drain_en = v;
    if (!v) m_sticky = 1'b0;
  endtask

  // One write cycle with the given channel mask; checks the combinational write port.
  task automatic write_mask(input logic [NCH-1:0] m);
    logic [NCH-1:0] exp_wren;
    exp_wren = '0;
    wr_req = m;
    for (int c = 0; c < NCH; c++) begin
      wdata[c] = $urandom;
      if (m[c]) begin
        if (mq[c].size() < DEPTH) begin
          exp_wren[c] = 1'b1;
          mq[c].push_back(wdata[c]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
    check("ram_wren", ram_wren, exp_wren);
    for (int c = 0; c < NCH; c++) begin
      if (exp_wren[c]) begin
        check("ram_wraddr", ram_wraddr[c*AW +: AW], m_wcnt[c] % DEPTH);
        m_wcnt[c]++;
      end
    end
    tick();
    wr_req = '0;
  endtask

  task automatic collect(input int n, input int budget, input bit rand_ready);
    int got = 0;
    int cyc = 0;
    int c;
    while (got < n && cyc < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      check("rden_onehot0", $onehot0(ram_rden), 1);
      if (out_valid) begin
        c = pick();
        if (c < 0) begin
          check("valid_with_no_data", out_valid, 0);
        end else begin
          check("out_chan", out_chan, c);
          check("out_data", out_data, mq[c][0]);
          if (out_ready) begin
            void'(mq[c].pop_front());
            m_last = c;
            m_sticky = 1'b1;
            got++;
          end
        end
      end
      if (got < n) begin
        tick();
        cyc++;
      end
    end
    if (got < n) check("collect_timeout", got, n);
  endtask

  task automatic wait_valid(input int budget);
    int cyc = 0;
    while (!out_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  initial begin
    int total;
    logic [DW-1:0] held_data;
    int cyc;

    // Reset values
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_ram_rden", ram_rden, 0);
    check("rst_overflow", overflow, 0);
    check("rst_empty", empty, 3'b111);
    check("rst_full", full, 3'b000);

    // Three words on ch0: latency and order
    set_drain(1'b1);
    out_ready = 1'b1;
    write_mask(3'b001);
    check("lat_e1_valid", out_valid, 0);
    write_mask(3'b001);
    check("lat_e2_valid", out_valid, 0);
    write_mask(3'b001);
    check("lat_e3_valid", out_valid, 0);
    tick();
    check("lat_first_valid", out_valid, 1);
    collect(3, 40, 1'b0);
    tick();
    check("t1_empty", empty, 3'b111);
    check("t1_out_valid", out_valid, 0);

    // Two words per channel, round-robin order
    do_reset();
    set_drain(1'b0);
    write_mask(3'b111);
    write_mask(3'b111);
    check("t2_empty", empty, 3'b000);
    set_drain(1'b1);
    out_ready = 1'b1;
    collect(6, 60, 1'b0);
    tick();
    check("t2_empty_end", empty, 3'b111);

    // Fill ch1 to the brim, overflow, then drain one
    do_reset();
    set_drain(1'b0);
    for (int i = 0; i < DEPTH; i++) write_mask(3'b010);
    check("t3_full", full, 3'b010);
    check("t3_empty", empty, 3'b101);
    check("t3_ovf_before", overflow, 0);
    write_mask(3'b010);
    check("t3_ovf_set", overflow, m_ovf);
    check("t3_full_kept", full, 3'b010);
    set_drain(1'b1);
    out_ready = 1'b1;
    collect(1, 20, 1'b0);
    set_drain(1'b0);
    check("t3_full_clear", full, 3'b000);
    tick();
    write_mask(3'b010);
    check("t3_refull", full, 3'b010);
    check("t3_ovf_sticky", overflow, 1);

    // Reset during HOLD discards everything; next word reads address 0
    out_ready = 1'b0;
    set_drain(1'b1);
    wait_valid(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_wcnt[c] = 0;
    end
    m_last = NCH - 1;
    m_ovf = 1'b0;
    m_sticky = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_empty", empty, 3'b111);
    check("t6_overflow", overflow, 0);
    check("t6_full", full, 3'b000);
    out_ready = 1'b1;
    write_mask(3'b010);
    cyc = 0;
    while (ram_rden == '0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t6_rden", ram_rden, 3'b010);
    check("t6_rdaddr", ram_rdaddr[1*AW +: AW], 0);
    collect(1, 10, 1'b0);
    tick();

    // Backpressure: HOLD stable for 10 cycles
    do_reset();
    set_drain(1'b1);
    out_ready = 1'b0;
    write_mask(3'b101);
    wait_valid(10);
    held_data = mq[0][0];
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_chan", out_chan, 0);
      check("bp_data", out_data, held_data);
      check("bp_rden", ram_rden, 0);
      check("bp_rdaddr", ram_rdaddr, {12'd0, 12'd0, 12'd1});
      check("bp_wraddr", ram_wraddr, {12'd1, 12'd0, 12'd1});
      check("bp_empty", empty, 3'b011);
      tick();
    end
    out_ready = 1'b1;
    collect(2, 40, 1'b0);
    tick();

    // drain_en dropped during WAIT: word completes, nothing further issues
    do_reset();
    set_drain(1'b1);
    out_ready = 1'b1;
    write_mask(3'b001);
    write_mask(3'b001);
    write_mask(3'b001);
    set_drain(1'b0);
    tick();
    collect(1, 4, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      check("de_rden", ram_rden, 0);
      check("de_valid", out_valid, 0);
      tick();
    end
    check("de_empty", empty, 3'b110);
    set_drain(1'b1);
    collect(2, 30, 1'b0);
    tick();

    // Random fill then random-backpressure drain
    do_reset();
    set_drain(1'b0);
    for (int i = 0; i < 300; i++) write_mask(3'($urandom_range(0, 7)));
    for (int c = 0; c < NCH; c++) check("rnd_empty", empty[c], mq[c].size() == 0);
    total = mq[0].size() + mq[1].size() + mq[2].size();
    set_drain(1'b1);
    collect(total, total * 12 + 20, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    check("rnd_empty_end", empty, 3'b111);
    check("rnd_overflow", overflow, m_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/outbuf_drain_sched.md
# outbuf_drain_sched

Read/write scheduler for the three per-channel output RAMs that sit between the switch datapath outputs and the host read port. Generates write addresses and enables from the producer write strobes, and tracks per-channel occupancy with full and empty flags. Arbitrates draining round-robin among non-empty channels, sequencing RAM read address, read enable and one-cycle read latency into a valid/ready word stream toward the host interface.

## Interface
Parameters:
- `NCH`, 3: number of output channels/RAMs
- `ADDR_W`, 12: RAM address width (depth 2^ADDR_W words)
- `DATA_W`, 32: RAM word width

Ports (clock is `clk`; reset is `reset`, synchronous, active-high, on the single clock `clk`):
- `clk` in 1: sole clock
- `reset` in 1: synchronous active-high reset
- `wr_req` in NCH: per-channel producer write strobe; data goes directly to RAM
- `ram_wren` out NCH: per-RAM write enable
- `ram_wraddr` out NCH*ADDR_W: per-RAM write address, channel i at bits [i*ADDR_W +: ADDR_W]
- `ram_rden` out NCH: per-RAM read enable
- `ram_rdaddr` out NCH*ADDR_W: per-RAM read address
- `ram_q` in NCH*DATA_W: per-RAM registered read data, valid one cycle after the `ram_rden` edge
- `drain_en` in 1: host permits draining
- `out_valid` out 1: `out_data`/`out_chan` hold a word
- `out_ready` in 1: host accepts the word
- `out_data` out DATA_W: drained word
- `out_chan` out 2: source channel of `out_data`
- `full`, `empty` out NCH: per-channel occupancy flags
- `overflow` out 1: sticky, set on any write dropped because the channel was full

## Operation
- Per channel: `wr_ptr`, `rd_ptr`, each ADDR_W+1 bits, wrapping modulo 2^(ADDR_W+1). RAM address is the low ADDR_W bits.
- `empty[i]` = (`wr_ptr` == `rd_ptr`). `full[i]` = (`wr_ptr` − `rd_ptr` == 2^ADDR_W).
- Write path:
  - `ram_wren[i]` = `wr_req[i]` & ~`full[i]` (combinational). `ram_wraddr[i]` = `wr_ptr[i]`.
  - `wr_ptr` increments at the edge when `ram_wren[i]` is high.
  - `wr_req` while full: no RAM write, pointer unchanged, `overflow` set. Only reset clears `overflow`.
- Drain FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if `drain_en` and any channel is non-empty, latch grant `g` (round-robin) and go to ISSUE.
  - ISSUE: `ram_rden[g]`=1 with `ram_rdaddr[g]`=`rd_ptr[g]`; `rd_ptr[g]`++; go to WAIT.
  - WAIT: at end of cycle, capture `ram_q[g]` into `out_data` and set `out_chan`=`g`; go to HOLD.
  - HOLD: `out_valid`=1; on `out_valid` & `out_ready`, go to IDLE.
- Round-robin: `last_grant` register, reset value NCH−1 (channel 0 has first priority). The grant is the first non-empty channel after `last_grant` in cyclic order. `last_grant` updates to `g` on entry to ISSUE.
- `drain_en` deasserted mid-word: the in-flight word completes through HOLD. No new ISSUE follows.
- Write and read on the same channel in the same cycle: both pointers update; flags stay consistent. A channel full at ISSUE accepts a write in the next cycle.
- `ram_rden` is low in every state except ISSUE, and only the granted bit is ever high.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `ram_rden`=0, `overflow`=0, all pointers 0, `empty`=all 1s, `full`=0, FSM=IDLE.
- `ram_wren`/`ram_wraddr` follow `wr_req` combinationally.
- Latency: a word written at edge N, with FSM idle and `drain_en`=1:
  - grant in cycle N
  - ISSUE in N+1
  - WAIT in N+2
  - `out_valid` high in N+3
- Throughput: one word per 4 cycles at best, when `out_ready` is held high.
- `out_data`/`out_chan` remain stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation discards the in-flight word and buffered occupancy; `out_valid` is low in the cycle after reset.

## Configuration
- `OUTBUF_BURST_DRAIN_EN` defined: the grant stays on `g` after each HOLD handshake until `g` is empty or `drain_en` falls. Only then does round-robin advance to the next non-empty channel.
- `OUTBUF_BURST_DRAIN_EN` undefined: round-robin re-arbitrates after every word, as described in Operation.

## Test plan
- Reset, then 3 writes to ch0 with `drain_en`=1 and `out_ready`=1 → 3 words with `out_chan`=0 in write order. First `out_valid` 3 cycles after the first write edge. Then `empty[0]`=1.
- 2 words each in ch0, ch1, ch2, default build → `out_chan` sequence 0,1,2,0,1,2. With `OUTBUF_BURST_DRAIN_EN` → 0,0,1,1,2,2.
- Fill ch1 with 4096 writes plus 1 extra → `full[1]`=1, extra write sees `ram_wren[1]`=0, `overflow`=1. Draining one word clears `full[1]`.
- Hold `out_ready`=0 for 10 cycles in HOLD → `out_valid`, `out_data`, `out_chan` stable, no `ram_rden`, pointers unchanged.
- Drop `drain_en` during WAIT → that word still delivered, then FSM stays IDLE with `ram_rden`=0 while data remains.
- Assert `reset` during HOLD → next cycle `out_valid`=0, all `empty`=1, `overflow`=0. A new write then drains from RAM address 0.
